// File: rtl/switch_debouncer.sv
// Synchronizes the raw slide-switch vector to clk and forwards a new value only
// after it has been seen unchanged for STABLE_CYCLES consecutive synchronized samples.
module switch_debouncer #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             btnC,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             changed,
  output logic [WIDTH-1:0] changed_mask,
  output logic             busy
);

  localparam int CntWidth = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(STABLE_CYCLES - 1);
  localparam logic [CntWidth-1:0] OneCnt  = CntWidth'(1);

  typedef enum logic {
    Idle     = 1'b0,
    Settling = 1'b1
  } debState;

  debState          state;
  logic [WIDTH-1:0] syncChain [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] candidate;
  logic [CntWidth-1:0] cnt;

  // Only syncChain[0] touches the asynchronous input.
  always_ff @(posedge clk) begin
    if (btnC) begin
      for (int i = 0; i < SYNC_STAGES; i++) syncChain[i] <= '0;
    end else begin
      syncChain[0] <= sw_in;
      for (int i = 1; i < SYNC_STAGES; i++) syncChain[i] <= syncChain[i-1];
    end
  end

  assign sync = syncChain[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (btnC) begin
      state        <= Idle;
      candidate    <= '0;
      cnt          <= '0;
      sw_out       <= '0;
      changed      <= 1'b0;
      changed_mask <= '0;
    end else begin
      changed      <= 1'b0;
      changed_mask <= '0;
      case (state)
        Idle: begin
          if (sync != sw_out) begin
            candidate <= sync;
            cnt       <= OneCnt;
            state     <= Settling;
          end
        end
        Settling: begin
          if (sync == candidate) begin
            if (cnt == LastCnt) begin
              sw_out       <= candidate;
              changed      <= 1'b1;
              changed_mask <= sw_out ^ candidate;
              cnt          <= '0;
              state        <= Idle;
            end else begin
              cnt <= cnt + OneCnt;
            end
          end else if (sync == sw_out) begin
            // Bounce returned to the accepted value: abandon quietly.
            cnt   <= '0;
            state <= Idle;
          end else begin
            // Any differing bit restarts the whole vector, so no partial update escapes.
            candidate <= sync;
            cnt       <= OneCnt;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

  assign busy = (state == Settling);

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
Input conditioning stage between the raw board slide switches and the operand/display logic. It synchronizes the asynchronous switch vector to clk and filters contact bounce. A new value is forwarded only after it has been stable for a programmable number of cycles. Downstream logic consumes sw_out as its operand bus {B, A} and may use changed/changed_mask to react to new operands.

Parameters:
WIDTH, 8, number of switch bits conditioned (sw_out[3:0] = A, sw_out[7:4] = B).
SYNC_STAGES, 2, flip-flop depth of the input synchronizer; legal range >= 2.
STABLE_CYCLES, 4, consecutive agreeing synchronized samples needed to accept a new value; legal range >= 2. The board build sets a ms-scale value; simulation uses 4.

Ports:
clk  input  1  system clock, all logic on rising edge
btnC  input  1  reset, synchronous, active-high
sw_in  input  WIDTH  raw asynchronous switch vector
sw_out  output  WIDTH  debounced, registered switch value
changed  output  1  one-cycle pulse on the cycle sw_out takes a new value
changed_mask  output  WIDTH  sw_out_old XOR sw_out_new, valid only while changed=1, else 0
busy  output  1  high while a candidate value is settling

Behaviour:
- Reset (btnC=1 at a rising edge): all sync stages, candidate, counter, sw_out, changed, changed_mask go to 0; state=IDLE; busy=0. Reset during SETTLING discards the candidate, with no changed pulse.
- Synchronizer: SYNC_STAGES-deep shift chain. "sync" denotes the last stage. No other logic samples sw_in directly.
- State IDLE:
  - sync == sw_out: hold.
  - sync != sw_out: candidate <= sync, cnt <= 1, go to SETTLING.
- State SETTLING:
  - sync == candidate and cnt == STABLE_CYCLES-1: sw_out <= candidate; changed <= 1; changed_mask <= sw_out ^ candidate; cnt <= 0; go to IDLE.
  - sync == candidate, otherwise: cnt <= cnt+1.
  - sync != candidate and sync == sw_out (glitch returned): cnt <= 0, go to IDLE, no pulse.
  - sync != candidate and sync != sw_out: candidate <= sync, cnt <= 1, stay in SETTLING (restart).
- busy = (state == SETTLING), decoded from the state register.
- changed and changed_mask are registered. They are high or nonzero for exactly one cycle, then return to 0 on the next edge unless another acceptance occurs. Back-to-back acceptances are impossible: the minimum spacing is STABLE_CYCLES cycles.
- Latency: if sw_in changes and then holds, sw_out updates on the (SYNC_STAGES + STABLE_CYCLES)-th rising edge, counting the first edge that samples the new value as edge 1. With defaults this is edge 6. changed is high in the cycle after that edge.
- cnt width is clog2(STABLE_CYCLES)+1. The counter never wraps, because it is cleared on acceptance.
- Multi-bit changes are treated as one vector. Any bit differing from the candidate restarts the count for the whole vector, so sw_out never shows a partially updated value.
- If sw_in is nonzero when reset is released, the block debounces normally to that value with full latency, and a changed pulse is produced.

Test Plan:
1. Reset with sw_in=0x00, then release; drive sw_in=0x5A and hold -> sw_out=0x00 through edge 5, 0x5A after edge 6; changed=1 for exactly one cycle; changed_mask=0x5A; busy high from edge 3 to edge 6.
2. Starting from sw_out=0x00, sw_in toggles 0x00/0x01 every cycle for 10 cycles, then holds 0x01 -> no sw_out change and no changed pulse during toggling; sw_out=0x01 six edges after the final change; mask=0x01.
3. Starting from sw_out=0x5A, sw_in=0x5B for 2 cycles, then back to 0x5A -> sw_out stays 0x5A; changed never asserts; busy rises, then returns to 0.
4. Starting from sw_out=0x00, sw_in=0x10 for 2 cycles, then 0x30 held -> sw_out goes directly to 0x30 (never 0x10); changed_mask=0x30.
5. Assert btnC while busy=1 during a 0x00->0x30 settle -> the next edge gives all outputs 0 and busy=0; after release with 0x30 held, the full 6-edge latency applies again and one changed pulse follows.
6. Sweep all 256 sw_in values, each held 8 cycles -> sw_out equals each value by the end of its window; exactly one changed pulse per distinct transition; changed_mask equals the XOR of consecutive values.
